// File: rtl/uart_bps_gen_pkg.sv
// Shared constants for the UART bit-rate generator and its controllers.
package uart_pkg;
  localparam int   DEFAULT_DIV = 1736;
  localparam int   OSR         = 16;
  localparam int   FRAME_BITS  = 10;
  localparam int   MIN_DIV     = 2 * OSR;
  localparam logic MODE_TX     = 1'b0;
  localparam logic MODE_RX     = 1'b1;
endpackage

// File: rtl/uart_bps_gen_if.sv
// Controller-facing bundle of the baud generator: run/divisor control in, strobes out.
interface uart_bps_gen_if #(
  parameter int DIV_W = 16
);
  logic             Count_Sig;
  logic             Mode;
  logic [DIV_W-1:0] Div_In;
  logic             Div_Load;
  logic             Div_Err;
  logic             BPS_CLK;
  logic             Bit_End;
  logic             Os_Tick;
  logic [3:0]       Bit_Idx;
  logic             Frame_Done;

  modport master (
    output Count_Sig, Mode, Div_In, Div_Load,
    input  Div_Err, BPS_CLK, Bit_End, Os_Tick, Bit_Idx, Frame_Done
  );

  modport slave (
    input  Count_Sig, Mode, Div_In, Div_Load,
    output Div_Err, BPS_CLK, Bit_End, Os_Tick, Bit_Idx, Frame_Done
  );
endinterface

// File: rtl/uart_bps_gen_os_tick.sv
// Receiver oversample tick generator: OSR evenly spaced ticks per bit, remainder clocks silent.
module uart_os_tick #(
  parameter int DIV_W = 16,
  parameter int OSR   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  input  logic             clr,
  input  logic             mode_rx,
  input  logic [DIV_W-1:0] os_div,
  output logic             os_tick
);
  localparam int NUM_W = $clog2(OSR) + 1;

  logic [DIV_W-1:0] os_cnt;
  logic [NUM_W-1:0] os_num;
  logic             os_last;

  assign os_last = (os_cnt == os_div - DIV_W'(1));

  // Sub-bit counter and tick tally; the tally saturates at OSR so the remainder yields no tick.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      os_cnt <= {DIV_W{1'b0}};
      os_num <= {NUM_W{1'b0}};
    end else if (run) begin
      if (os_last) begin
        os_cnt <= {DIV_W{1'b0}};
        if (os_num < NUM_W'(OSR)) begin
          os_num <= os_num + NUM_W'(1);
        end
      end else begin
        os_cnt <= os_cnt + DIV_W'(1);
      end
    end
  end

  assign os_tick = mode_rx && run && os_last && (os_num < NUM_W'(OSR));
endmodule

// File: rtl/uart_bps_gen.sv
// UART baud-rate generator: per-bit clock counter with loadable divisor, bit strobes and frame index.
module uart_bps_gen #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = uart_pkg::DEFAULT_DIV,
  parameter int OSR         = uart_pkg::OSR,
  parameter int FRAME_BITS  = uart_pkg::FRAME_BITS
) (
  input  logic            CLK,
  input  logic            RST,
  uart_bps_gen_if.slave   bus
);
  import uart_pkg::*;

  localparam int OS_SH = $clog2(OSR);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] os_div;
  logic [DIV_W-1:0] cnt;
  logic [3:0]       bit_q;
  logic             div_err;
  logic             idle;
  logic             last_clk;
  logic             load_ok;

  assign idle     = !bus.Count_Sig && (cnt == {DIV_W{1'b0}});
  assign last_clk = (cnt == div_q - DIV_W'(1));
  assign load_ok  = bus.Div_Load && idle && (bus.Div_In >= DIV_W'(2 * OSR));

  // Divisor register: loads only between frames; anything else is reported as a rejected load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q   <= DIV_W'(DEFAULT_DIV);
      os_div  <= DIV_W'(DEFAULT_DIV >> OS_SH);
      div_err <= 1'b0;
    end else begin
      if (load_ok) begin
        div_q  <= bus.Div_In;
        os_div <= bus.Div_In >> OS_SH;
      end
      div_err <= bus.Div_Load && !load_ok;
    end
  end

  // Bit counter and bit index; dropping Count_Sig abandons the frame and outranks a bit boundary.
  always_ff @(posedge CLK) begin
    if (RST || !bus.Count_Sig) begin
      cnt   <= {DIV_W{1'b0}};
      bit_q <= 4'd0;
    end else if (last_clk) begin
      cnt   <= {DIV_W{1'b0}};
      bit_q <= (bit_q == 4'(FRAME_BITS - 1)) ? 4'd0 : bit_q + 4'd1;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  uart_os_tick #(
    .DIV_W (DIV_W),
    .OSR   (OSR)
  ) u_os_tick (
    .CLK     (CLK),
    .RST     (RST),
    .run     (bus.Count_Sig),
    .clr     (!bus.Count_Sig || last_clk),
    .mode_rx (bus.Mode == MODE_RX),
    .os_div  (os_div),
    .os_tick (bus.Os_Tick)
  );

  assign bus.Div_Err    = div_err;
  assign bus.BPS_CLK    = (cnt == (div_q >> 1));
  assign bus.Bit_End    = bus.Count_Sig && last_clk;
  assign bus.Frame_Done = bus.Count_Sig && last_clk && (bit_q == 4'(FRAME_BITS - 1));
  assign bus.Bit_Idx    = bit_q;
endmodule

// File: tb/tb_uart_bps_gen.sv
// Randomised and directed bench for uart_bps_gen against an edge-count reference model.
module tb_uart_bps_gen;
  localparam int DEF  = 1736;
  localparam int OSR  = 16;
  localparam int FBIT = 10;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  uart_bps_gen_if #(.DIV_W(16)) bus ();

  uart_bps_gen #(
    .DIV_W(16), .DEFAULT_DIV(DEF), .OSR(OSR), .FRAME_BITS(FBIT)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: enabled edges since frame start, active divisor, pending error pulse.
  int e     = 0;
  int div   = DEF;
  bit err_m = 1'b0;

  int en_edges;
  int first_bps, first_bend, first_fd, first_b1, first_os, last_os, os_count;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_obs(input logic cs, input logic md);
    int  pos, bidx, osd;
    logic bps, bend, fd, os;
    pos  = e % div;
    bidx = (e / div) % FBIT;
    osd  = div >> 4;
    bps  = (pos == div / 2);
    bend = cs && (pos == div - 1);
    fd   = bend && (bidx == FBIT - 1);
    os   = md && cs && (((pos + 1) % osd) == 0) && (((pos + 1) / osd) <= OSR);
    return {err_m, bps, bend, os, fd, 4'(bidx)};
  endfunction

  task automatic clr_rec();
    first_bps = -1; first_bend = -1; first_fd = -1; first_b1 = -1;
    first_os = -1; last_os = -1; os_count = 0;
  endtask

  // One clock: drive, compare against the model, clock, advance the model.
  task automatic tick(input logic rst, input logic cs, input logic md,
                      input logic ld, input logic [15:0] din);
    logic [8:0] obs;
    bit idle;
    RST = rst; bus.Count_Sig = cs; bus.Mode = md; bus.Div_Load = ld; bus.Div_In = din;
    #1;
    obs = {bus.Div_Err, bus.BPS_CLK, bus.Bit_End, bus.Os_Tick, bus.Frame_Done, bus.Bit_Idx};
    check_eq("cycle", 32'(obs), 32'(model_obs(cs, md)));
    if (bus.BPS_CLK && first_bps < 0 && cs) first_bps = en_edges;
    if (bus.Bit_End && first_bend < 0) first_bend = en_edges;
    if (bus.Frame_Done && first_fd < 0) first_fd = en_edges;
    if (bus.Bit_Idx == 4'd1 && first_b1 < 0) first_b1 = en_edges;
    if (bus.Os_Tick) begin
      if (first_os < 0) first_os = en_edges;
      last_os = en_edges;
      os_count++;
    end
    @(posedge CLK);
    if (rst) begin
      e = 0; div = DEF; err_m = 1'b0; en_edges = 0;
    end else begin
      idle  = !cs && (e % div == 0);
      err_m = ld && !(idle && int'(din) >= 2 * OSR);
      if (ld && idle && int'(din) >= 2 * OSR) div = int'(din);
      if (cs) begin
        e++; en_edges++;
      end else begin
        e = 0; en_edges = 0;
      end
    end
    #1;
  endtask

  task automatic run(input int n, input logic cs, input logic md);
    for (int i = 0; i < n; i++) tick(1'b0, cs, md, 1'b0, 16'd0);
  endtask

  function automatic logic [15:0] pick_div();
    case ($urandom_range(0, 3))
      0:       return 16'd20;
      1:       return 16'd31;
      2:       return 16'd32;
      default: return 16'($urandom_range(32, 400));
    endcase
  endfunction

  initial begin
    logic md;
    bus.Count_Sig = 1'b0; bus.Mode = 1'b0; bus.Div_Load = 1'b0; bus.Div_In = 16'd0;
    en_edges = 0;
    clr_rec();
    @(posedge CLK); #1;

    // Reset defaults, then one full TX frame at the default divisor.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    check_eq("reset_outs", 32'({bus.Div_Err, bus.BPS_CLK, bus.Bit_End, bus.Os_Tick,
                                bus.Frame_Done, bus.Bit_Idx}), 32'd0);
    clr_rec();
    run(17360, 1'b1, 1'b0);
    check_eq("s1_bps", 32'(first_bps), 32'd868);
    check_eq("s1_bend", 32'(first_bend), 32'd1735);
    check_eq("s1_idx1", 32'(first_b1), 32'd1736);
    check_eq("s1_fd", 32'(first_fd), 32'd17359);
    check_eq("s1_idx_wrap", 32'(bus.Bit_Idx), 32'd0);

    // Idle load of 434 is accepted and used by the next frame.
    run(2, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 16'd434);
    check_eq("s2_no_err", 32'(bus.Div_Err), 32'd0);
    clr_rec();
    run(868, 1'b1, 1'b0);
    check_eq("s2_bps", 32'(first_bps), 32'd217);
    check_eq("s2_bend", 32'(first_bend), 32'd433);

    // Mid-frame load is rejected; too-small idle load is rejected.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    clr_rec();
    run(500, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 16'd434);
    check_eq("s3_busy_err", 32'(bus.Div_Err), 32'd1);
    run(3472 - 501, 1'b1, 1'b0);
    check_eq("s3_bend", 32'(first_bend), 32'd1735);
    check_eq("s3_idx2", 32'(bus.Bit_Idx), 32'd2);
    run(2, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 16'd20);
    check_eq("s3_small_err", 32'(bus.Div_Err), 32'd1);
    clr_rec();
    run(1736, 1'b1, 1'b0);
    check_eq("s3_keep_div", 32'(first_bend), 32'd1735);

    // RX oversampling at divisor 434: 16 ticks, 27 clocks apart, last at cnt 431.
    run(2, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 16'd434);
    clr_rec();
    run(434, 1'b1, 1'b1);
    check_eq("s4_os_count", 32'(os_count), 32'd16);
    check_eq("s4_os_first", 32'(first_os), 32'd26);
    check_eq("s4_os_last", 32'(last_os), 32'd431);

    // Abandon a frame at bit 4, cnt 900.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    run(4 * 1736 + 900, 1'b1, 1'b0);
    check_eq("s5_pre_idx", 32'(bus.Bit_Idx), 32'd4);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    check_eq("s5_drop", 32'({bus.BPS_CLK, bus.Bit_End, bus.Frame_Done, bus.Bit_Idx}), 32'd0);

    // Reset mid-frame with a simultaneous load: defaults restored.
    run(2, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 16'd434);
    run(300, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 16'd434);
    check_eq("s6_rst_outs", 32'({bus.Div_Err, bus.BPS_CLK, bus.Bit_End, bus.Os_Tick,
                                 bus.Frame_Done, bus.Bit_Idx}), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    clr_rec();
    run(1736, 1'b1, 1'b0);
    check_eq("s6_bps", 32'(first_bps), 32'd868);
    check_eq("s6_bend", 32'(first_bend), 32'd1735);

    // Random frames, divisors, loads and resets, all checked every cycle by the model.
    for (int it = 0; it < 30; it++) begin
      md = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) tick(1'b1, 1'b0, md, 1'b0, 16'd0);
      run(2, 1'b0, md);
      tick(1'b0, 1'b0, md, 1'($urandom_range(0, 1)), pick_div());
      for (int k = 0, n = $urandom_range(1, 1000); k < n; k++) begin
        tick(1'b0, 1'b1, md, ($urandom_range(0, 99) == 0), pick_div());
      end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
